// File: rtl/memory_access.sv
// memory_access: memory stage of the RV64 pipeline.
// Takes the execute register, runs at most one data-bus transaction per
// memory instruction, and produces the writeback register, the decode
// bypass source and this stage's ok_to_proceed vote.
// Optional build macro: MEMACC_FAST_DONE_EN. When it is defined, a data_ok
// can complete the instruction in the same cycle, skipping the DONE state.

package memory_access_pkg;

    typedef struct packed {
        logic        valid;
        logic        isWriteBack;
        logic [4:0]  wd;
        logic [63:0] aluOut;
        logic [63:0] rs2;
        logic        isMemRead;
        logic        isMemWrite;
        logic [2:0]  memMode;
        logic        isBranch;
        logic [63:0] pcBranch;
        logic [63:0] instrAddr;
        logic [31:0] instr;
    } REG_EX_MEM;

    typedef struct packed {
        logic        valid;
        logic        isWriteBack;
        logic [4:0]  wd;
        logic [63:0] wdData;
        logic [63:0] instrAddr;
        logic [31:0] instr;
        logic        isMem;
    } REG_MEM_WB;

    typedef struct packed {
        logic        valid;
        logic        isWb;
        logic [4:0]  wd;
        logic [63:0] wdData;
    } FORWARD_SOURCE;

endpackage

// state | meaning
// IDLE  | no transaction outstanding; a memop drives the request this cycle
// REQ   | request presented but not yet accepted; request fields held
// WAIT  | request accepted, waiting for data_ok
// DONE  | transaction finished, result in ld_data, waiting for the pipeline
module memory_access
    import memory_access_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  REG_EX_MEM     moduleIn,
    output REG_MEM_WB     moduleOut,
    output FORWARD_SOURCE forwardSource,
    output logic          ok_to_proceed,
    input  logic          ok_to_proceed_overall,
    output logic          dreq_valid,
    output logic [63:0]   dreq_addr,
    output logic [2:0]    dreq_size,
    output logic [7:0]    dreq_strobe,
    output logic [63:0]   dreq_data,
    input  logic          dresp_addr_ok,
    input  logic          dresp_data_ok,
    input  logic [63:0]   dresp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] ld_data;

    logic        memop;
    logic [2:0]  off;
    logic [1:0]  size;
    logic [5:0]  shamt;
    logic        issuing;
    logic        finish_now;
    logic        fast_done;
    logic [63:0] raw;
    logic [63:0] ld_fmt;
    logic [63:0] ld_now;
    logic [7:0]  byte_mask;

    // Branch information ends its life in execute; it is deliberately dropped.
    logic unused_branch;
    assign unused_branch = ^{moduleIn.isBranch, moduleIn.pcBranch};

    assign memop   = moduleIn.valid & (moduleIn.isMemRead | moduleIn.isMemWrite);
    assign off     = moduleIn.aluOut[2:0];
    assign size    = moduleIn.memMode[1:0];
    assign shamt   = {off, 3'b000};

    // Only IDLE and REQ put a request on the bus, so a stalled instruction
    // never issues a second transaction once it has been accepted.
    assign issuing = memop & ((state == S_IDLE) | (state == S_REQ));

    // The transaction completes this cycle (request and data both seen).
    assign finish_now = (issuing & dresp_addr_ok & dresp_data_ok)
                      | ((state == S_WAIT) & dresp_data_ok);

    assign dreq_valid  = issuing;
    assign dreq_addr   = moduleIn.aluOut;
    assign dreq_size   = {1'b0, size};
    assign dreq_data   = moduleIn.rs2 << shamt;
    assign dreq_strobe = moduleIn.isMemWrite ? (byte_mask << off) : 8'h00;

    assign raw = dresp_data >> shamt;

    // Byte lanes touched by an access of the current size, before alignment.
    always_comb begin
        byte_mask = 8'h01;
        case (size)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    end

    // Extract the addressed bytes from the bus line and sign/zero-extend.
    always_comb begin
        ld_fmt = '0;
        case (size)
            2'd0: ld_fmt = moduleIn.memMode[2] ? {56'd0, raw[7:0]}
                                               : {{56{raw[7]}}, raw[7:0]};
            2'd1: ld_fmt = moduleIn.memMode[2] ? {48'd0, raw[15:0]}
                                               : {{48{raw[15]}}, raw[15:0]};
            2'd2: ld_fmt = moduleIn.memMode[2] ? {32'd0, raw[31:0]}
                                               : {{32{raw[31]}}, raw[31:0]};
            default: ld_fmt = raw;
        endcase
    end

`ifdef MEMACC_FAST_DONE_EN
    // A completing transaction lets the stage advance in the same cycle,
    // using the freshly formatted bus data instead of the latched copy.
    assign fast_done = finish_now;
    assign ld_now    = fast_done ? ld_fmt : ld_data;
`else
    assign fast_done = 1'b0;
    assign ld_now    = ld_data;
`endif

    assign ok_to_proceed = ~memop | (state == S_DONE) | fast_done;

    // Bus handshake sequencing and load-result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ld_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_REQ: begin
                    if (!memop) begin
                        state <= S_IDLE;
                    end else if (dresp_addr_ok & dresp_data_ok) begin
                        ld_data <= ld_fmt;
                        state   <= (fast_done & ok_to_proceed_overall) ? S_IDLE : S_DONE;
                    end else if (dresp_addr_ok) begin
                        state <= S_WAIT;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (dresp_data_ok) begin
                        ld_data <= ld_fmt;
                        state   <= (fast_done & ok_to_proceed_overall) ? S_IDLE : S_DONE;
                    end
                end
                default: begin
                    if (ok_to_proceed_overall) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Writeback register advances only when the whole pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            moduleOut <= '0;
        end else if (ok_to_proceed_overall) begin
            moduleOut.valid       <= moduleIn.valid;
            moduleOut.isWriteBack <= moduleIn.isWriteBack;
            moduleOut.wd          <= moduleIn.wd;
            moduleOut.wdData      <= moduleIn.isMemRead ? ld_now : moduleIn.aluOut;
            moduleOut.instrAddr   <= moduleIn.instrAddr;
            moduleOut.instr       <= moduleIn.instr;
            moduleOut.isMem       <= moduleIn.isMemRead | moduleIn.isMemWrite;
        end
    end

    // Bypass source; a load is not forwardable until its data is latched.
    always_comb begin
        forwardSource        = '0;
        forwardSource.valid  = moduleIn.valid & (moduleIn.wd != 5'd0);
        forwardSource.isWb   = moduleIn.isWriteBack & ~(moduleIn.isMemRead & (state != S_DONE));
        forwardSource.wd     = moduleIn.wd;
        forwardSource.wdData = moduleIn.isMemRead ? ld_data : moduleIn.aluOut;
    end

endmodule
